ascon_data_absorb: RTL and testbench
====================================

// Module: ascon_data_absorb
// PURPOSE
// Ascon-128a plaintext/ciphertext processing stage. It sits between associated-data absorption and finalization.
// - Takes the 320-bit state after AD absorption and domain separation, and absorbs 128-bit rate blocks.
// - Emits ciphertext (encrypt) or plaintext (decrypt) per block, running the p8 permutation between non-last blocks.
// - Hands the final state to finalization, which XORs the key in and runs p12.
// - The permutation is iterated in-block, one round per cycle.
// PARAMETERS
// ROUNDS   8   rounds of intermediate permutation pb; round r uses const {4'hF-r[3:0], r[3:0]}, r = 12-ROUNDS .. 11
// PORTS
// clk          in   1    clock, rising edge
// rst          in   1    asynchronous active-high reset
// start        in   1    load init_state and begin a message (accepted only in IDLE or DONE)
// decrypt      in   1    sampled with start: 0 = encrypt, 1 = decrypt
// init_state   in   320  state after AD + domain separation; S0 = [319:256] .. S4 = [63:0]
// din_valid    in   1    input block valid
// din_ready    out  1    block accepted when din_valid & din_ready
// din          in   128  PT/CT block, first byte in [127:120]
// din_last     in   1    final block of message
// din_len      in   4    valid bytes of last block, 0..15; ignored (treated as 16) when din_last = 0
// dout_valid   out  1    one-cycle pulse: dout holds CT/PT of the accepted block
// dout         out  128  output block; bytes >= din_len of a last block are forced to 0
// final_valid  out  1    level: final_state valid, held until next start or reset
// final_state  out  320  state for finalization (key not applied)
// BEHAVIOUR
// - Reset values: state 0, FSM IDLE, din_ready 0, dout_valid 0, dout 0, final_valid 0, final_state 0.
// - FSM states: IDLE -> (start) ABSORB; ABSORB -> (accept, !last) PERM; ABSORB -> (accept, last) DONE.
// - PERM runs ROUNDS cycles, then returns to ABSORB; DONE -> (start) ABSORB.
// - din_ready = 1 only in ABSORB. start in ABSORB/PERM is ignored; the message cannot be aborted except by rst.
// - Rate R = state[319:192]. Padding for last block of n bytes: pad = 128'h80 << (8*(15-n)); mask M = top n bytes set.
// - Encrypt, non-last block: R' = R ^ din; dout = R'.
// - Encrypt, last block: R' = R ^ (din & M) ^ pad; dout = R' & M.
// - Decrypt, non-last block: dout = R ^ din; R' = din.
// - Decrypt, last block: dout = (R ^ din) & M; R' = (din & M) | (R & ~M) ^ pad.
// - Capacity [191:0] is unchanged by absorption.
// - Latency: dout_valid asserts the cycle after accept.
// - Non-last blocks: din_ready returns ROUNDS+1 cycles after accept (1 absorb, ROUNDS perm cycles).
// - Last block: final_valid rises the cycle after accept, same cycle as dout_valid. No permutation on the last block.
// - Empty message: a single last block with din_len = 0 (pad only). A full final 16-byte block is sent as non-last, then a len-0 last block.
// - Round (one per PERM cycle): S2 ^= const; 5-bit Ascon S-box on each bit slice.
// - Linear layer: Si ^= rotr(Si,a) ^ rotr(Si,b), with (a,b) = S0:(19,28) S1:(61,39) S2:(1,6) S3:(10,17) S4:(7,41).
// - Round counter is 4 bits, runs 0..ROUNDS-1 and clears on exit; no wrap beyond.
// - din_len > 15 is not possible (4-bit); din_len is don't-care for non-last blocks.
// - rst mid-message: immediate return to reset values; downstream must discard partial output.
// - final_state == the internal state register in DONE; final_valid drops the cycle after start is accepted.
// TESTING
// T1 reset: assert rst mid-PERM -> all outputs 0 next edge; din_ready 0 until a new start.
// T2 empty msg: init_state 0, encrypt, last len 0 -> dout_valid, dout 0; final_state = {8'h80, 312'h0}; no PERM cycles.
// T3 decrypt passthrough: init 0, ct 128'h0011..EEFF non-last -> dout = same value.
//    din_ready low exactly 9 cycles; final state matches a golden model after a len-0 last block.
// T4 partial last: encrypt, init S0S1 = all-ones, din = 0, len 5 -> dout = {40'hFF..FF, 88'h0}.
//    R' = {40'hFF..FF, 8'h7F, 80'hFF..FF}.
// T5 round-trip: random 3.5-block message, encrypt then decrypt from the same init_state.
//    Plaintext is recovered and both final_state values are equal.
// T6 golden: Ascon-128a KAT state (key/nonce 000102..0F, AD 00, PT 00..1F) vs software model.
//    Checks every dout and final_state; start held during ABSORB is ignored.

Source files
------------

// File: rtl/ascon_data_absorb_if.sv
// rtl/ascon_data_absorb_if.sv - message/block handshake bundle for the Ascon data absorption stage
interface ascon_data_absorb_if;
    logic         start;
    logic         decrypt;
    logic [319:0] init_state;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] din;
    logic         din_last;
    logic [3:0]   din_len;
    logic         dout_valid;
    logic [127:0] dout;
    logic         final_valid;
    logic [319:0] final_state;

    modport master (
        output start, decrypt, init_state, din_valid, din, din_last, din_len,
        input  din_ready, dout_valid, dout, final_valid, final_state
    );

    modport slave (
        input  start, decrypt, init_state, din_valid, din, din_last, din_len,
        output din_ready, dout_valid, dout, final_valid, final_state
    );
endinterface

// File: rtl/ascon_data_absorb.sv
// rtl/ascon_data_absorb.sv - Ascon-128a PT/CT absorption with iterated pb permutation
module ascon_data_absorb #(
    parameter int ROUNDS = 8
) (
    input logic                clk,
    input logic                rst,
    ascon_data_absorb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         decrypt_q, decrypt_d;
    logic         din_ready_q, din_ready_d;
    logic         dout_valid_q, dout_valid_d;
    logic [127:0] dout_q, dout_d;
    logic         final_valid_q, final_valid_d;
    logic [319:0] final_state_q, final_state_d;

    logic         accept;
    logic [127:0] rate;
    logic [127:0] mask;
    logic [127:0] pad;
    logic [3:0]   pad_pos;
    logic [127:0] rate_new;
    logic [127:0] dout_new;
    logic [3:0]   r_idx;
    logic [7:0]   rc;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'h0, c};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Rate absorption datapath: byte mask and padding for a partial last block.
    always_comb begin
        accept   = (fsm_q == ABSORB) && din_ready_q && bus.din_valid;
        rate     = state_q[319:192];
        pad_pos  = 4'd15 - bus.din_len;
        mask     = {128{1'b1}};
        pad      = '0;
        if (bus.din_last) begin
            mask = ~({128{1'b1}} >> {bus.din_len, 3'b000});
            pad  = 128'h80 << {pad_pos, 3'b000};
        end
        if (decrypt_q) begin
            dout_new = (rate ^ bus.din) & mask;
            rate_new = ((bus.din & mask) | (rate & ~mask)) ^ pad;
        end else begin
            rate_new = rate ^ (bus.din & mask) ^ pad;
            dout_new = rate_new & mask;
        end
        r_idx = rnd_q + 4'(12 - ROUNDS);
        rc    = {4'hF - r_idx, r_idx};
    end

    // Control FSM and next-state for all registered outputs.
    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        rnd_d         = rnd_q;
        decrypt_d     = decrypt_q;
        din_ready_d   = 1'b0;
        dout_valid_d  = 1'b0;
        dout_d        = dout_q;
        final_valid_d = final_valid_q;
        final_state_d = final_state_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d       = bus.init_state;
                    decrypt_d     = bus.decrypt;
                    fsm_d         = ABSORB;
                    final_valid_d = 1'b0;
                    final_state_d = '0;
                end
            end
            ABSORB: begin
                if (accept) begin
                    state_d      = {rate_new, state_q[191:0]};
                    dout_d       = dout_new;
                    dout_valid_d = 1'b1;
                    if (bus.din_last) begin
                        fsm_d         = DONE;
                        final_valid_d = 1'b1;
                        final_state_d = {rate_new, state_q[191:0]};
                    end else begin
                        fsm_d = PERM;
                    end
                end else begin
                    din_ready_d = 1'b1;
                end
            end
            PERM: begin
                state_d = ascon_round(state_q, rc);
                if (rnd_q == 4'(ROUNDS - 1)) begin
                    rnd_d = 4'd0;
                    fsm_d = ABSORB;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q         <= IDLE;
            state_q       <= '0;
            rnd_q         <= 4'd0;
            decrypt_q     <= 1'b0;
            din_ready_q   <= 1'b0;
            dout_valid_q  <= 1'b0;
            dout_q        <= '0;
            final_valid_q <= 1'b0;
            final_state_q <= '0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            rnd_q         <= rnd_d;
            decrypt_q     <= decrypt_d;
            din_ready_q   <= din_ready_d;
            dout_valid_q  <= dout_valid_d;
            dout_q        <= dout_d;
            final_valid_q <= final_valid_d;
            final_state_q <= final_state_d;
        end
    end

    assign bus.din_ready   = din_ready_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout        = dout_q;
    assign bus.final_valid = final_valid_q;
    assign bus.final_state = final_state_q;

endmodule

// File: tb/tb_ascon_data_absorb.sv
// tb/tb_ascon_data_absorb.sv - directed self-checking bench for ascon_data_absorb
module tb_ascon_data_absorb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ascon_data_absorb_if bus();

    ascon_data_absorb #(.ROUNDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [191:0] CAP = 192'h0123456789ABCDEF_0F1E2D3C4B5A6978_DEADBEEFCAFEF00D;

    typedef struct {
        logic         dec;
        logic [319:0] init;
        logic [127:0] din;
        logic [3:0]   len;
        logic [127:0] exp_dout;
        logic [127:0] exp_rate;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] mdl_perm(input logic [319:0] s, input int nr);
        logic [63:0] x[5];
        logic [63:0] t[5];
        for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] ^= 64'(((15 - r) << 4) | r);
            x[0] ^= x[4];
            x[4] ^= x[3];
            x[2] ^= x[1];
            for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
            for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
            x[1] ^= x[0];
            x[0] ^= x[4];
            x[3] ^= x[2];
            x[2] = ~x[2];
            x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
            x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
            x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
            x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
            x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Byte-oriented reference of one block, including pb after a non-last block.
    function automatic void mdl_block(input logic [319:0] s_in, input logic dec, input logic [127:0] d,
                                      input logic last, input logic [3:0] len,
                                      output logic [319:0] s_out, output logic [127:0] dout);
        int n;
        logic [7:0] rb, db;
        n = last ? int'(len) : 16;
        s_out = s_in;
        dout = '0;
        for (int i = 0; i < 16; i++) begin
            rb = s_in[319-8*i -: 8];
            db = d[127-8*i -: 8];
            if (i < n) begin
                dout[127-8*i -: 8] = rb ^ db;
                s_out[319-8*i -: 8] = dec ? db : (rb ^ db);
            end else if (i == n) begin
                s_out[319-8*i -: 8] = rb ^ 8'h80;
            end
        end
        if (!last) s_out = mdl_perm(s_out, 8);
    endfunction

    task automatic do_start(input logic [319:0] init, input logic dec);
        @(negedge clk);
        bus.start = 1'b1;
        bus.init_state = init;
        bus.decrypt = dec;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input logic last, input logic [3:0] len,
                              output logic [127:0] dout_act);
        int guard;
        guard = 0;
        while (bus.din_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: din_ready stayed %b, want 1", bus.din_ready);
        end
        bus.din_valid = 1'b1;
        bus.din = d;
        bus.din_last = last;
        bus.din_len = len;
        @(negedge clk);
        bus.din_valid = 1'b0;
        chk("dout_valid", bus.dout_valid, 1'b1);
        dout_act = bus.dout;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] got;
        logic [319:0] ms, ms2, init5, init6, fs_enc;
        logic [127:0] pt[4], ct[4], rec[4], md;
        logic [127:0] k128;
        int cnt;

        vecs[0] = '{1'b0, 320'h0, 128'h0, 4'd0, 128'h0, {8'h80, 120'h0}};
        vecs[1] = '{1'b0, {{16{8'hFF}}, CAP}, 128'h0, 4'd5,
                    {{5{8'hFF}}, 88'h0}, {{5{8'hFF}}, 8'h7F, {10{8'hFF}}}};
        vecs[2] = '{1'b0, {128'h0, CAP}, 128'h00112233445566778899AABBCCDDEEFF, 4'd15,
                    128'h00112233445566778899AABBCCDDEE00, 128'h00112233445566778899AABBCCDDEE80};
        vecs[3] = '{1'b1, {{16{8'hA5}}, CAP}, {16{8'hA5}}, 4'd3,
                    128'h0, {{3{8'hA5}}, 8'h25, {12{8'hA5}}}};
        vecs[4] = '{1'b1, {128'h0, CAP}, {16{8'hFF}}, 4'd15,
                    {{15{8'hFF}}, 8'h00}, {{15{8'hFF}}, 8'h80}};
        vecs[5] = '{1'b0, {128'h0123456789ABCDEF_FEDCBA9876543210, CAP}, {16{8'hFF}}, 4'd8,
                    128'hFEDCBA9876543210_0000000000000000, 128'hFEDCBA9876543210_7EDCBA9876543210};
        vecs[6] = '{1'b1, {{16{8'h55}}, CAP}, 128'h123456789ABCDEF0123456789ABCDEF0, 4'd0,
                    128'h0, {8'hD5, {15{8'h55}}}};

        bus.start = 1'b0;
        bus.decrypt = 1'b0;
        bus.init_state = '0;
        bus.din_valid = 1'b0;
        bus.din = '0;
        bus.din_last = 1'b0;
        bus.din_len = '0;

        repeat (3) @(negedge clk);
        chk("rst_din_ready", bus.din_ready, 1'b0);
        chk("rst_dout_valid", bus.dout_valid, 1'b0);
        chk("rst_dout", bus.dout, 128'h0);
        chk("rst_final_valid", bus.final_valid, 1'b0);
        chk("rst_final_state", bus.final_state, 320'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", bus.din_ready, 1'b0);

        // Single last-block messages: no permutation, result visible directly.
        for (int v = 0; v < 7; v++) begin
            do_start(vecs[v].init, vecs[v].dec);
            chk("start_clears_final", bus.final_valid, 1'b0);
            send_block(vecs[v].din, 1'b1, vecs[v].len, got);
            chk("vec_dout", got, vecs[v].exp_dout);
            chk("vec_final_valid", bus.final_valid, 1'b1);
            chk("vec_final_state", bus.final_state, {vecs[v].exp_rate, vecs[v].init[191:0]});
            repeat (3) @(negedge clk);
            chk("vec_done_stable", {bus.din_ready, bus.final_valid, bus.final_state},
                {1'b0, 1'b1, vecs[v].exp_rate, vecs[v].init[191:0]});
        end

        // Reset in the middle of a permutation.
        do_start({{16{8'h3C}}, CAP}, 1'b0);
        send_block(128'h1, 1'b0, 4'd0, got);
        chk("t1_pre_dout", got, {{15{8'h3C}}, 8'h3D});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_din_ready", bus.din_ready, 1'b0);
        chk("t1_dout_valid", bus.dout_valid, 1'b0);
        chk("t1_dout", bus.dout, 128'h0);
        chk("t1_final_valid", bus.final_valid, 1'b0);
        chk("t1_final_state", bus.final_state, 320'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_ready_after_rst", bus.din_ready, 1'b0);

        // Decrypt passthrough with zero state, then ready gap and final state.
        do_start(320'h0, 1'b1);
        send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b0, 4'd0, got);
        chk("t3_dout", got, 128'h00112233445566778899AABBCCDDEEFF);
        cnt = 0;
        while (bus.din_ready !== 1'b1 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("t3_ready_gap", cnt, 9);
        mdl_block(320'h0, 1'b1, 128'h00112233445566778899AABBCCDDEEFF, 1'b0, 4'd0, ms, md);
        mdl_block(ms, 1'b1, 128'h0, 1'b1, 4'd0, ms2, md);
        send_block(128'h0, 1'b1, 4'd0, got);
        chk("t3_last_dout", got, md);
        chk("t3_final_state", bus.final_state, ms2);

        // Round trip over a 3.5-block message.
        for (int i = 0; i < 10; i++) init5[319-32*i -: 32] = $urandom;
        for (int i = 0; i < 4; i++) pt[i] = {$urandom, $urandom, $urandom, $urandom};
        do_start(init5, 1'b0);
        ms = init5;
        for (int i = 0; i < 4; i++) begin
            send_block(pt[i], i == 3, 4'd8, ct[i]);
            mdl_block(ms, 1'b0, pt[i], i == 3, 4'd8, ms2, md);
            ms = ms2;
            chk("t5_ct", ct[i], md);
        end
        fs_enc = bus.final_state;
        chk("t5_enc_final", fs_enc, ms);
        do_start(init5, 1'b1);
        for (int i = 0; i < 4; i++) send_block(ct[i], i == 3, 4'd8, rec[i]);
        for (int i = 0; i < 3; i++) chk("t5_pt", rec[i], pt[i]);
        chk("t5_pt_last", rec[3], {pt[3][127:64], 64'h0});
        chk("t5_final_equal", bus.final_state, fs_enc);

        // Full Ascon-128a flow: init, AD 00, PT 00..1F; start held high mid-message.
        k128 = 128'h000102030405060708090A0B0C0D0E0F;
        init6 = mdl_perm({64'h80800C0800000000, k128, k128}, 12);
        init6[127:0] ^= k128;
        init6[319:192] ^= {8'h00, 8'h80, 112'h0};
        init6 = mdl_perm(init6, 8);
        init6[0] ^= 1'b1;
        do_start(init6, 1'b0);
        bus.start = 1'b1;
        bus.decrypt = 1'b1;
        bus.init_state = {320{1'b1}};
        ms = init6;
        send_block(k128, 1'b0, 4'd0, got);
        mdl_block(ms, 1'b0, k128, 1'b0, 4'd0, ms2, md);
        ms = ms2;
        chk("t6_ct0", got, md);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        bus.init_state = init6;
        bus.decrypt = 1'b0;
        send_block(128'h101112131415161718191A1B1C1D1E1F, 1'b0, 4'd0, got);
        mdl_block(ms, 1'b0, 128'h101112131415161718191A1B1C1D1E1F, 1'b0, 4'd0, ms2, md);
        ms = ms2;
        chk("t6_ct1", got, md);
        send_block(128'h0, 1'b1, 4'd0, got);
        mdl_block(ms, 1'b0, 128'h0, 1'b1, 4'd0, ms2, md);
        chk("t6_ct_last", got, md);
        chk("t6_final_valid", bus.final_valid, 1'b1);
        chk("t6_final_state", bus.final_state, ms2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
